// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS32 pipeline constants and MEM stage types
package mips_pkg;

  localparam int XLEN = 32;

  localparam int CU_REGWRITE = 3;
  localparam int CU_MEMTOREG = 2;
  localparam int CU_MEMREAD  = 1;
  localparam int CU_MEMWRITE = 0;

  // {RegWrite, MemtoReg, load data, ALU result, rd}
  localparam int MEM_WB_W = 2 * XLEN + 7;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

endpackage

// File: rtl/pipeline_register.sv
// rtl/pipeline_register.sv - generic pipeline register with hold and sync active-low reset
module pipeline_register #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_hold_data,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_data;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_data <= '0;
    end else if (!i_hold_data) begin
      r_data <= i_data;
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/memory_access_stage.sv
// rtl/memory_access_stage.sv - MEM stage: data memory req/ack access, stall/timeout, MEM/WB register
module memory_access_stage
  import mips_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        EX_MEM_CU_signals,
  input  logic [DATA_W-1:0] EX_MEM_ALU_result,
  input  logic [DATA_W-1:0] EX_MEM_DMEM_wr_data,
  input  logic [4:0]        EX_MEM_wr_addr,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              Mem_Stall,
  output logic              Mem_Err,
  output logic              MEM_WB_RegWrite,
  output logic [4:0]        MEM_WB_rd_field,
  output logic [DATA_W-1:0] MEM_WB_wr_data
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam int WB_W  = MEM_WB_W + 2 * (DATA_W - XLEN);

  mem_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_err;
  logic              w_mem_op, w_misaligned, w_complete, w_abort, w_err_set;
  logic [DATA_W-1:0] w_load_data;
  logic [WB_W-1:0]   w_wb_in, w_wb_out;
  logic              w_wb_memtoreg;
  logic [DATA_W-1:0] w_wb_rdata, w_wb_alu;

  assign w_mem_op     = EX_MEM_CU_signals[CU_MEMREAD] | EX_MEM_CU_signals[CU_MEMWRITE];
  assign w_misaligned = w_mem_op && (EX_MEM_ALU_result[1:0] != 2'b00);

  assign dmem_we    = EX_MEM_CU_signals[CU_MEMWRITE];
  assign dmem_addr  = EX_MEM_ALU_result;
  assign dmem_wdata = EX_MEM_DMEM_wr_data;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    dmem_req    = 1'b0;
    Mem_Stall   = 1'b0;
    w_complete  = 1'b0;
    w_abort     = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (w_misaligned) begin
          w_err_set = 1'b1;
        end else if (w_mem_op) begin
          dmem_req = 1'b1;
          if (dmem_ack) begin
            w_complete = 1'b1;
          end else begin
            Mem_Stall   = 1'b1;
            w_state_nxt = WAIT;
            w_cnt_nxt   = CNT_W'(1);
          end
        end
      end
      WAIT: begin
        // Request stays up through the final cycle so a last-moment ack still completes.
        dmem_req = 1'b1;
        if (dmem_ack) begin
          w_complete  = 1'b1;
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt >= CNT_W'(TIMEOUT_CYC)) begin
          w_abort     = 1'b1;
          w_err_set   = 1'b1;
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          Mem_Stall = 1'b1;
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (!rst) begin
      dmem_req  = 1'b0;
      Mem_Stall = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  assign Mem_Err     = r_err;
  assign w_load_data = w_complete ? dmem_rdata : {DATA_W{1'b0}};

  // Stalled cycles push bubbles; failed accesses retire without a register write.
  always_comb begin
    w_wb_in = '0;
    if (!Mem_Stall) begin
      w_wb_in = {EX_MEM_CU_signals[CU_REGWRITE] & ~(w_misaligned | w_abort),
                 EX_MEM_CU_signals[CU_MEMTOREG],
                 w_load_data,
                 EX_MEM_ALU_result,
                 EX_MEM_wr_addr};
    end
  end

  pipeline_register #(.WIDTH(WB_W)) u_mem_wb (
    .i_clk       (clk),
    .i_rst_n     (rst),
    .i_hold_data (1'b0),
    .i_data      (w_wb_in),
    .o_data      (w_wb_out)
  );

  assign MEM_WB_RegWrite = w_wb_out[WB_W-1];
  assign w_wb_memtoreg   = w_wb_out[WB_W-2];
  assign w_wb_rdata      = w_wb_out[WB_W-3 -: DATA_W];
  assign w_wb_alu        = w_wb_out[5 +: DATA_W];
  assign MEM_WB_rd_field = w_wb_out[4:0];
  assign MEM_WB_wr_data  = w_wb_memtoreg ? w_wb_rdata : w_wb_alu;

endmodule

// File: tb/tb_memory_access_stage.sv
// tb/tb_memory_access_stage.sv - self-checking bench for memory_access_stage
module tb_memory_access_stage;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  EX_MEM_CU_signals;
  logic [31:0] EX_MEM_ALU_result, EX_MEM_DMEM_wr_data;
  logic [4:0]  EX_MEM_wr_addr;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        Mem_Stall, Mem_Err, MEM_WB_RegWrite;
  logic [4:0]  MEM_WB_rd_field;
  logic [31:0] MEM_WB_wr_data;

  memory_access_stage #(.DATA_W(32), .TIMEOUT_CYC(TMO)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .EX_MEM_CU_signals   (EX_MEM_CU_signals),
    .EX_MEM_ALU_result   (EX_MEM_ALU_result),
    .EX_MEM_DMEM_wr_data (EX_MEM_DMEM_wr_data),
    .EX_MEM_wr_addr      (EX_MEM_wr_addr),
    .dmem_req            (dmem_req),
    .dmem_we             (dmem_we),
    .dmem_addr           (dmem_addr),
    .dmem_wdata          (dmem_wdata),
    .dmem_rdata          (dmem_rdata),
    .dmem_ack            (dmem_ack),
    .Mem_Stall           (Mem_Stall),
    .Mem_Err             (Mem_Err),
    .MEM_WB_RegWrite     (MEM_WB_RegWrite),
    .MEM_WB_rd_field     (MEM_WB_rd_field),
    .MEM_WB_wr_data      (MEM_WB_wr_data)
  );

  always #5 clk = ~clk;

  int   n_chk  = 0;
  int   n_pass = 0;
  logic exp_err;
  logic last_rw;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: an accepted access waits lat cycles for ack (stalling each one) unless lat exceeds
  // the timeout, in which case it stalls TMO cycles and aborts; writeback follows the final edge.
  task automatic run_instr(input logic [3:0] c, input logic [31:0] a, input logic [31:0] w,
                           input logic [4:0] r, input int lat, input logic [31:0] rdat);
    logic memop, mis, acc, tout, exp_rw;
    int   last;
    memop = c[1] | c[0];
    mis   = memop && (a[1:0] != 2'b00);
    acc   = memop && !mis;
    tout  = acc && (lat > TMO);
    last  = !acc ? 0 : ((lat < TMO) ? lat : TMO);
    EX_MEM_CU_signals   = c;
    EX_MEM_ALU_result   = a;
    EX_MEM_DMEM_wr_data = w;
    EX_MEM_wr_addr      = r;
    for (int cyc = 0; cyc <= last; cyc++) begin
      dmem_ack   = acc ? (cyc == lat) : 1'($urandom_range(0, 1));
      dmem_rdata = (acc && cyc == lat) ? rdat : $urandom;
      #1;
      chk("stall", Mem_Stall, acc && (cyc < last));
      chk("req", dmem_req, acc);
      if (acc) begin
        chk("we", dmem_we, c[0]);
        chk("addr", dmem_addr, a);
        if (c[0]) chk("wdata", dmem_wdata, w);
      end
      tick();
      if (cyc < last) begin
        chk("bubble_rw", MEM_WB_RegWrite, 1'b0);
        chk("bubble_rd", MEM_WB_rd_field, 5'd0);
      end
    end
    dmem_ack = 1'b0;
    exp_rw   = c[3] && !mis && !tout;
    exp_err  = exp_err | mis | tout;
    last_rw  = exp_rw;
    chk("wb_rw", MEM_WB_RegWrite, exp_rw);
    chk("err", Mem_Err, exp_err);
    if (exp_rw) begin
      chk("wb_rd", MEM_WB_rd_field, r);
      chk("wb_data", MEM_WB_wr_data, c[2] ? rdat : a);
    end
  endtask

  typedef struct {
    logic [3:0]  cu;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  rd;
    int          lat;
    logic [31:0] rdat;
    logic        exp_rw;
    logic [31:0] exp_data;
    logic        exp_e;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{4'b1000, 32'h0000_0010, 32'h0, 5'd5,  0,  32'h0,         1'b1, 32'h0000_0010, 1'b0};
    tbl[1] = '{4'b1110, 32'h0000_0040, 32'h0, 5'd7,  0,  32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 1'b0};
    tbl[2] = '{4'b0001, 32'h0000_0044, 32'h1234_5678, 5'd0, 3, 32'h0,   1'b0, 32'h0,         1'b0};
    tbl[3] = '{4'b1110, 32'h0000_0042, 32'h0, 5'd8,  0,  32'h1111_1111, 1'b0, 32'h0,         1'b1};
    tbl[4] = '{4'b1000, 32'hABCD_0000, 32'h0, 5'd31, 0,  32'h0,         1'b1, 32'hABCD_0000, 1'b1};
    tbl[5] = '{4'b1110, 32'h0000_0100, 32'h0, 5'd3,  99, 32'h0,         1'b0, 32'h0,         1'b1};
    tbl[6] = '{4'b1011, 32'h0000_0048, 32'hCAFE_F00D, 5'd4, 1, 32'h0,   1'b1, 32'h0000_0048, 1'b1};
    tbl[7] = '{4'b1110, 32'h0000_004C, 32'h0, 5'd9,  TMO, 32'h55AA_55AA, 1'b1, 32'h55AA_55AA, 1'b1};

    rst = 1'b0;
    EX_MEM_CU_signals = '0; EX_MEM_ALU_result = '0; EX_MEM_DMEM_wr_data = '0; EX_MEM_wr_addr = '0;
    dmem_ack = 1'b0; dmem_rdata = '0;
    exp_err = 1'b0; last_rw = 1'b0;
    tick(); tick();
    chk("rst_req", dmem_req, 1'b0);
    chk("rst_stall", Mem_Stall, 1'b0);
    chk("rst_err", Mem_Err, 1'b0);
    chk("rst_rw", MEM_WB_RegWrite, 1'b0);
    chk("rst_rd", MEM_WB_rd_field, 5'd0);
    chk("rst_data", MEM_WB_wr_data, 32'h0);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_instr(tbl[i].cu, tbl[i].alu, tbl[i].wd, tbl[i].rd, tbl[i].lat, tbl[i].rdat);
      chk($sformatf("tbl%0d_rw", i), MEM_WB_RegWrite, tbl[i].exp_rw);
      chk($sformatf("tbl%0d_err", i), Mem_Err, tbl[i].exp_e);
      if (tbl[i].exp_rw) chk($sformatf("tbl%0d_data", i), MEM_WB_wr_data, tbl[i].exp_data);
    end

    // After the timeout abort a following ALU op must see no lingering request.
    run_instr(4'b1000, 32'h0000_0077, 32'h0, 5'd2, 0, 32'h0);

    // Reset in the middle of a pending load.
    EX_MEM_CU_signals = 4'b1110; EX_MEM_ALU_result = 32'h80; EX_MEM_wr_addr = 5'd6;
    dmem_ack = 1'b0;
    #1;
    chk("mw_stall0", Mem_Stall, 1'b1);
    tick(); tick();
    chk("mw_req_wait", dmem_req, 1'b1);
    rst = 1'b0;
    tick();
    chk("mw_req_rst", dmem_req, 1'b0);
    chk("mw_stall_rst", Mem_Stall, 1'b0);
    rst = 1'b1;
    EX_MEM_CU_signals = 4'b0000;
    #1;
    chk("mw_req", dmem_req, 1'b0);
    chk("mw_stall", Mem_Stall, 1'b0);
    chk("mw_rw", MEM_WB_RegWrite, 1'b0);
    chk("mw_rd", MEM_WB_rd_field, 5'd0);
    chk("mw_data", MEM_WB_wr_data, 32'h0);
    chk("mw_err", Mem_Err, 1'b0);
    exp_err = 1'b0;

    for (int n = 0; n < 150; n++) begin
      logic [3:0]  c;
      logic [31:0] a;
      int          kind, lat;
      kind = $urandom_range(0, 3);
      a    = {$urandom_range(0, 1023), 2'b00};
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      case (kind)
        0:       c = {1'($urandom_range(0, 1)), 3'b000};
        1:       c = 4'b1110;
        2:       c = {1'($urandom_range(0, 1)), 3'b001};
        default: c = {1'($urandom_range(0, 1)), 1'b0, 2'b11};
      endcase
      lat = ($urandom_range(0, 19) == 0) ? TMO + 3 : $urandom_range(0, 4);
      run_instr(c, a, $urandom, 5'($urandom_range(0, 31)), lat, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
